// File: rtl/led_bounce_pkg.sv
// Shared types and constants for the LED bounce display blocks
// (position stepper, direction FSM, and related display logic).
package led_bounce_pkg;

  localparam int unsigned POS_W_DEF = 3;
  localparam int unsigned DIV_W_DEF = 24;

  // Direction encoding shared with the bounce-direction FSM
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic [1:0] {
    STOP      = 2'd0,
    RUN       = 2'd1,
    STEP_IDLE = 2'd2,
    STEP_ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/led_pos_stepper_tick_prescaler.sv
// tick_prescaler: counts clk cycles and flags every (div_val+1)-th one.
// div_val is sampled live; lowering it below the running count skips one
// compare and the counter wraps at 2**DIV_W before matching again.
module tick_prescaler
  import led_bounce_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [DIV_W-1:0] i_div_val,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic             o_tick_pulse_c
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_match;

  assign w_match        = (r_cnt == i_div_val);
  assign o_tick_pulse_c = i_enable && !i_clear && w_match;

  // Free-running count, reset on match or clear
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (w_match) r_cnt <= '0;
      else         r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pos_stepper.sv
// led_pos_stepper: saturating position stepper driving an LED bar.
// Steps on prescaled ticks (mode=0) or one step per req/ack handshake
// (mode=1). Optional macro LED_TRAIL_EN lights the previous position too.
module led_pos_stepper
  import led_bounce_pkg::*;
#(
  parameter int unsigned POS_W = POS_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                en,
  input  logic                mode,
  input  logic                dir,
  input  logic [DIV_W-1:0]    div_val,
  input  logic                step_req,
  output logic                step_ack,
  output logic [POS_W-1:0]    pos,
  output logic [2**POS_W-1:0] leds,
  output logic                tick,
  output logic                bounce
);

  localparam int unsigned      LED_W   = 2**POS_W;
  localparam logic [POS_W-1:0] MAX_POS = {POS_W{1'b1}};

  state_t             r_state, w_state_nxt;
  logic [POS_W-1:0]   r_pos, w_pos_nxt;
  logic [LED_W-1:0]   r_leds, w_leds_nxt;
  logic               r_tick, r_ack, r_bounce, r_req_q;
  logic               w_run, w_tick, w_adv, w_ack_nxt, w_tick_nxt, w_bounce_nxt;

  // Prescaler only counts while settled in free-run; any exit clears it
  assign w_run = (r_state == RUN) && en && !mode;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk            (clk),
    .arst           (arst),
    .i_div_val      (div_val),
    .i_clear        (!w_run),
    .i_enable       (w_run),
    .o_tick_pulse_c (w_tick)
  );

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= STOP;
    else      r_state <= w_state_nxt;
  end

  // Next state, advance request and handshake control
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_ack_nxt   = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      STOP: begin
        if (en) w_state_nxt = mode ? STEP_IDLE : RUN;
      end
      RUN: begin
        if (!en || mode) begin
          w_state_nxt = STOP;
        end else begin
          w_adv      = w_tick;
          w_tick_nxt = w_tick;
        end
      end
      STEP_IDLE: begin
        // Rising edge of req only, so a req held across a disable is ignored
        if (!en || !mode) begin
          w_state_nxt = STOP;
        end else if (step_req && !r_req_q) begin
          w_adv       = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = STEP_ACK;
        end
      end
      STEP_ACK: begin
        if (!en || !mode)  w_state_nxt = STOP;
        else if (step_req) w_ack_nxt   = 1'b1;
        else               w_state_nxt = STEP_IDLE;
      end
      default: w_state_nxt = STOP;
    endcase
  end

  // Saturating advance and bound-arrival detection
  always_comb begin
    w_pos_nxt = r_pos;
    if (w_adv) begin
      if (dir == DIR_RIGHT) begin
        if (r_pos != MAX_POS) w_pos_nxt = r_pos + POS_W'(1);
      end else begin
        if (r_pos != '0)      w_pos_nxt = r_pos - POS_W'(1);
      end
    end
    w_bounce_nxt = w_adv && (w_pos_nxt != r_pos) &&
                   ((w_pos_nxt == MAX_POS) || (w_pos_nxt == '0));
  end

`ifdef LED_TRAIL_EN
  logic [POS_W-1:0] r_prev_pos, w_prev_nxt;

  // prev_pos follows every advance event, so it equals pos when saturated
  assign w_prev_nxt = w_adv ? r_pos : r_prev_pos;
  assign w_leds_nxt = (LED_W'(1) << w_pos_nxt) | (LED_W'(1) << w_prev_nxt);

  // Trail position register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_prev_pos <= '0;
    else      r_prev_pos <= w_prev_nxt;
  end
`else
  assign w_leds_nxt = LED_W'(1) << w_pos_nxt;
`endif

  // Registered outputs; leds decoded from next pos so it aligns with pos
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_pos    <= '0;
      r_leds   <= LED_W'(1);
      r_tick   <= 1'b0;
      r_ack    <= 1'b0;
      r_bounce <= 1'b0;
      r_req_q  <= 1'b0;
    end else begin
      r_pos    <= w_pos_nxt;
      r_leds   <= w_leds_nxt;
      r_tick   <= w_tick_nxt;
      r_ack    <= w_ack_nxt;
      r_bounce <= w_bounce_nxt;
      r_req_q  <= step_req;
    end
  end

  assign pos      = r_pos;
  assign leds     = r_leds;
  assign tick     = r_tick;
  assign step_ack = r_ack;
  assign bounce   = r_bounce;

endmodule

// File: tb/tb_led_pos_stepper.sv
// Directed bench for led_pos_stepper (default POS_W=3, DIV_W=24).
// Expected LED images follow LED_TRAIL_EN when the bench is built with it.
module tb_led_pos_stepper;

  logic        clk, arst, en, mode, dir, step_req;
  logic [23:0] div_val;
  logic        step_ack, tick, bounce;
  logic [2:0]  pos;
  logic [7:0]  leds;

  logic dir_tb, dir_loop, loop_on;
  int   n_chk, n_pass;

  assign dir = loop_on ? dir_loop : dir_tb;

  led_pos_stepper dut (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .div_val  (div_val),
    .step_req (step_req),
    .step_ack (step_ack),
    .pos      (pos),
    .leds     (leds),
    .tick     (tick),
    .bounce   (bounce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural direction FSM: flips one edge after pos reaches a bound
  always @(posedge clk or posedge arst) begin
    if (arst)           dir_loop <= 1'b1;
    else if (pos == 3'd7) dir_loop <= 1'b0;
    else if (pos == 3'd0) dir_loop <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] led_exp(input int p, input int q);
    logic [7:0] one;
    one = 8'h01;
`ifdef LED_TRAIL_EN
    return (one << p) | (one << q);
`else
    if (q < 0) return 8'h00;  // q unused in the plain decode
    return one << p;
`endif
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    if (!tick) check("tick_timeout", 32'(0), 32'(1));
  endtask

  task automatic step_once();
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
  endtask

  int n;
  int seq [18] = '{0,1,2,3,4,5,6,7,7,6,5,4,3,2,1,0,0,1};

  initial begin
    n_chk = 0; n_pass = 0;
    arst = 1'b1; en = 1'b0; mode = 1'b0; dir_tb = 1'b1; loop_on = 1'b0;
    div_val = 24'd3; step_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pos",    32'(pos),      32'(0));
    check("rst_leds",   32'(leds),     32'h01);
    check("rst_tick",   32'(tick),     32'(0));
    check("rst_ack",    32'(step_ack), 32'(0));
    check("rst_bounce", 32'(bounce),   32'(0));
    arst = 1'b0;

    // Free-run up to pos=5, then asynchronous reset mid-cycle
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_tick(n);
      check("fr_a_period", 32'(n),    32'((k == 1) ? 5 : 4));
      check("fr_a_pos",    32'(pos),  32'(k));
      check("fr_a_leds",   32'(leds), 32'(led_exp(k, k - 1)));
    end
    #2 arst = 1'b1;
    #1;
    check("arst_pos",    32'(pos),      32'(0));
    check("arst_leds",   32'(leds),     32'h01);
    check("arst_tick",   32'(tick),     32'(0));
    check("arst_ack",    32'(step_ack), 32'(0));
    check("arst_bounce", 32'(bounce),   32'(0));
    @(negedge clk);
    arst = 1'b0;

    // Full free-run 1..7 and one saturated tick
    for (int k = 1; k <= 7; k++) begin
      wait_tick(n);
      check("fr_period", 32'(n),      32'((k == 1) ? 5 : 4));
      check("fr_pos",    32'(pos),    32'(k));
      check("fr_bounce", 32'(bounce), 32'(k == 7));
      check("fr_leds",   32'(leds),   32'(led_exp(k, k - 1)));
    end
    wait_tick(n);
    check("sat_period", 32'(n),      32'(4));
    check("sat_pos",    32'(pos),    32'(7));
    check("sat_bounce", 32'(bounce), 32'(0));
    check("sat_leds",   32'(leds),   32'h80);
    @(negedge clk);
    check("tick_single", 32'(tick), 32'(0));

    // Closed loop with direction model, tick every cycle
    en = 1'b0; arst = 1'b1;
    @(negedge clk);
    arst = 1'b0; div_val = 24'd0; loop_on = 1'b1; en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("loop_pos", 32'(pos), 32'(seq[i]));
      check("loop_bounce", 32'(bounce),
            32'((i > 0) && (seq[i] != seq[i-1]) && (seq[i] == 0 || seq[i] == 7)));
      check("loop_leds", 32'(leds), 32'(led_exp(seq[i], (i > 0) ? seq[i-1] : 0)));
    end

    // Single-step handshake
    en = 1'b0; loop_on = 1'b0; arst = 1'b1;
    @(negedge clk);
    arst = 1'b0; mode = 1'b1; dir_tb = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    check("ss_idle_pos", 32'(pos),      32'(0));
    check("ss_idle_ack", 32'(step_ack), 32'(0));
    step_once();
    step_once();
    check("ss_pos2", 32'(pos), 32'(2));
    step_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("ss_hold_pos", 32'(pos),      32'(3));
      check("ss_hold_ack", 32'(step_ack), 32'(1));
    end
    check("ss_leds3", 32'(leds), 32'(led_exp(3, 2)));
    step_req = 1'b0;
    @(negedge clk);
    check("ss_drop_ack", 32'(step_ack), 32'(0));
    check("ss_drop_pos", 32'(pos),      32'(3));

    // en dropped during STEP_ACK with req held
    step_req = 1'b1;
    @(negedge clk);
    check("abort_pos4", 32'(pos),      32'(4));
    check("abort_ack1", 32'(step_ack), 32'(1));
    check("abort_leds", 32'(leds),     32'(led_exp(4, 3)));
    en = 1'b0;
    @(negedge clk);
    check("abort_ack0", 32'(step_ack), 32'(0));
    check("abort_pos",  32'(pos),      32'(4));
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("reen_pos", 32'(pos),      32'(4));
    check("reen_ack", 32'(step_ack), 32'(0));
    step_req = 1'b0;
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    check("toggle_pos", 32'(pos),      32'(5));
    check("toggle_ack", 32'(step_ack), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_pos_stepper.md
Name: led_pos_stepper

Overview:
- Position datapath that consumes the direction bit from the bounce-direction FSM and produces the position the FSM watches.
- Advances pos by one step per prescaled tick (free-run) or per request/acknowledge handshake (single-step).
- Saturates at the bounds and drives the LED bar decode.
- Sits between the board clock/switch inputs and the LED outputs; pos feeds back to the direction FSM.

Parameters:
- POS_W, 3, position width; MAX_POS = 2**POS_W-1.
- DIV_W, 24, prescaler compare width.

Ports:
- clk  input  1  system clock
- arst  input  1  asynchronous active-high reset
- en  input  1  1 = stepping enabled, 0 = frozen
- mode  input  1  0 = free-run on prescaled tick, 1 = single-step handshake
- dir  input  1  1 = increment, 0 = decrement (from direction FSM)
- div_val  input  DIV_W  tick period minus one, in clk cycles
- step_req  input  1  single-step request (level)
- step_ack  output  1  single-step acknowledge
- pos  output  POS_W  current position 0..MAX_POS
- leds  output  2**POS_W  LED bar image of pos
- tick  output  1  one-cycle pulse on every free-run advance event
- bounce  output  1  one-cycle pulse when pos becomes 0 or MAX_POS after a move

Behaviour:
- Reset (arst high, asynchronous): state=STOP, pos=0, prescaler cnt=0, tick=0, step_ack=0, bounce=0, leds=1 (bit0).
- All outputs are registered. leds is decoded from the registered pos, so it updates in the same cycle as pos.
- States:
  - STOP: pos held, cnt held at 0. Next state is RUN when en&!mode, or STEP_IDLE when en&mode.
  - RUN: cnt increments each cycle. When cnt==div_val: cnt<=0, tick=1 next cycle, pos advances at that edge. div_val=0 gives a tick and advance every cycle.
  - STEP_IDLE: cnt held at 0. When step_req=1: pos advances at that edge, step_ack=1 from the next cycle, go to STEP_ACK.
  - STEP_ACK: step_ack stays 1 until step_req is sampled 0, then step_ack<=0 and return to STEP_IDLE. One advance per request; a held req never produces a second step.
- Advance rule (saturating, never wraps):
  - dir=1 and pos<MAX_POS: pos+1.
  - dir=0 and pos>0: pos-1.
  - Otherwise pos held.
  - The direction FSM flips dir on the clk edge after pos reaches a bound, so the next advance moves away from the bound. A tick landing while dir is stale is absorbed by saturation.
- bounce=1 for one cycle after an advance that changes pos into 0 or MAX_POS. No pulse on a saturated (held) advance.
- en falling in any state: go to STOP next edge, cnt<=0, step_ack<=0, pos retained. Any in-flight handshake is abandoned.
- mode change while en=1: takes effect via STOP (one-cycle pass-through), then the new mode state. cnt is cleared on the way.
- div_val is sampled live. If it is lowered below the current cnt, cnt==div_val is missed once and cnt wraps naturally at 2**DIV_W; this is acceptable and documented.
- Simultaneous en=0 and tick compare: en wins, no advance.

Optional Feature:
- Macro: LED_TRAIL_EN.
- Defined: leds = onehot(pos) | onehot(prev_pos). prev_pos is the value pos held before its last change, so two adjacent LEDs light after a move. Reset sets prev_pos=0, giving leds=1. prev_pos equals pos when saturated.
- Undefined: leds = onehot(pos) strictly. No prev_pos register is synthesized.

Decomposition:
- Shared package led_bounce_pkg:
  - State encodings STOP/RUN/STEP_IDLE/STEP_ACK.
  - Default POS_W and DIV_W.
  - Constants DIR_RIGHT=1, DIR_LEFT=0, also used by the direction FSM.
- Sub-module tick_prescaler (cnt, div_val, clear, enable -> tick_pulse), reusable by other display blocks.
- The one-hot/trail decode stays inline.

Test Plan:
- Reset mid-run: assert arst while pos=5 in RUN -> pos=0, leds=8'h01, tick/step_ack/bounce=0 immediately.
- Free-run, div_val=3, dir=1, en=1, mode=0 -> tick every 4 cycles; pos 0,1,2..7; bounce one cycle after pos=7; leds=8'h80.
- Closed loop with the direction FSM, div_val=0 -> pos sequence 0..7,7,6..0,0,1; no value outside 0..7; bounce at each end.
- Single-step: mode=1, hold step_req high 10 cycles -> exactly one advance (pos 2->3); step_ack high until the cycle after req drops.
- en dropped during STEP_ACK with step_req still high -> step_ack=0 next cycle, pos unchanged; re-enable -> no extra step until req toggles.
- LED_TRAIL_EN defined, pos 3->4 -> leds=8'h18; saturated at 7 for two ticks -> leds=8'h80.
